// File: rtl/snake_body.sv
// Snake body datapath: shift-register segment store, head stepping, wall/self collision and growth.
// Optional build macro SNAKE_WRAP_EN makes the grid edges wrap instead of killing the snake.
module snake_body #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int XW       = 6,
  parameter int YW       = 5,
  parameter int MAX_LEN  = 32,
  parameter int LW       = 6,
  parameter int INIT_LEN = 3
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          move,
  input  logic          dir_valid,
  input  logic [1:0]    dir,
  input  logic [XW-1:0] fruit_x,
  input  logic [YW-1:0] fruit_y,
  input  logic [LW-1:0] rd_index,
  output logic [XW-1:0] rd_x,
  output logic [YW-1:0] rd_y,
  output logic          rd_active,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [LW-1:0] length,
  output logic          busy,
  output logic          ate_fruit,
  output logic          endgame
);

  localparam int IW = $clog2(MAX_LEN);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_SCAN, S_COMMIT, S_DEAD} state_t;

  state_t state_reg, state_next;

  logic [XW-1:0] seg_x [MAX_LEN];
  logic [YW-1:0] seg_y [MAX_LEN];
  logic [LW-1:0] len_reg;
  logic [LW-1:0] scan_idx;
  logic [LW-1:0] scan_limit;
  logic [1:0]    cur_dir;
  logic [1:0]    pend_dir;
  logic [XW-1:0] nx_calc, nx_reg;
  logic [YW-1:0] ny_calc, ny_reg;
  logic          grow_reg;
  logic          out_of_grid;
  logic          wall_hit;
  logic          scan_hit;
  logic          commit;
  logic          respawn;

  // Candidate head one cell along cur_dir, with the wrapped coordinate precomputed.
  always_comb begin
    nx_calc     = seg_x[0];
    ny_calc     = seg_y[0];
    out_of_grid = 1'b0;
    case (cur_dir)
      2'd0: if (seg_y[0] == '0) begin
        out_of_grid = 1'b1;
        ny_calc     = YW'(GRID_H - 1);
      end else ny_calc = seg_y[0] - 1'b1;
      2'd1: if (seg_x[0] == XW'(GRID_W - 1)) begin
        out_of_grid = 1'b1;
        nx_calc     = '0;
      end else nx_calc = seg_x[0] + 1'b1;
      2'd2: if (seg_x[0] == '0) begin
        out_of_grid = 1'b1;
        nx_calc     = XW'(GRID_W - 1);
      end else nx_calc = seg_x[0] - 1'b1;
      default: if (seg_y[0] == YW'(GRID_H - 1)) begin
        out_of_grid = 1'b1;
        ny_calc     = '0;
      end else ny_calc = seg_y[0] + 1'b1;
    endcase
  end

`ifdef SNAKE_WRAP_EN
  assign wall_hit = 1'b0;
`else
  assign wall_hit = out_of_grid;
`endif

  // The tail cell is vacated on a plain step, so it is only scanned when growing.
  assign scan_limit = grow_reg ? (len_reg - LW'(1)) : (len_reg - LW'(2));
  assign scan_hit   = (seg_x[scan_idx[IW-1:0]] == nx_reg) && (seg_y[scan_idx[IW-1:0]] == ny_reg);

  always_ff @(posedge clock) begin
    if (!resetn) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    ate_fruit  = 1'b0;
    endgame    = 1'b0;
    commit     = 1'b0;
    respawn    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        if (move) state_next = S_CALC;
      end
      S_CALC:   state_next = wall_hit ? S_DEAD : S_SCAN;
      S_SCAN: begin
        if (scan_hit)                     state_next = S_DEAD;
        else if (scan_idx == scan_limit)  state_next = S_COMMIT;
      end
      S_COMMIT: begin
        commit     = 1'b1;
        ate_fruit  = grow_reg;
        state_next = S_IDLE;
      end
      S_DEAD: begin
        endgame    = 1'b1;
        respawn    = 1'b1;
        state_next = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn || respawn) begin
      len_reg  <= LW'(INIT_LEN);
      grow_reg <= 1'b0;
      scan_idx <= '0;
      nx_reg   <= '0;
      ny_reg   <= '0;
    end else begin
      if (state_reg == S_CALC) begin
        nx_reg   <= nx_calc;
        ny_reg   <= ny_calc;
        grow_reg <= (nx_calc == fruit_x) && (ny_calc == fruit_y);
        scan_idx <= '0;
      end
      if (state_reg == S_SCAN) scan_idx <= scan_idx + LW'(1);
      if (commit && grow_reg && (len_reg != LW'(MAX_LEN))) len_reg <= len_reg + LW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn || respawn) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= (i < INIT_LEN) ? XW'(GRID_W / 2 - i) : '0;
        seg_y[i] <= (i < INIT_LEN) ? YW'(GRID_H / 2) : '0;
      end
    end else if (commit) begin
      seg_x[0] <= nx_reg;
      seg_y[0] <= ny_reg;
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_x[i] <= seg_x[i-1];
        seg_y[i] <= seg_y[i-1];
      end
    end
  end

  // Reversal check uses the committed direction, so a quick turn-then-reverse is still allowed.
  always_ff @(posedge clock) begin
    if (!resetn || respawn) begin
      cur_dir  <= 2'd1;
      pend_dir <= 2'd1;
    end else begin
      if (dir_valid && (({1'b0, dir} + {1'b0, cur_dir}) != 3'd3)) pend_dir <= dir;
      if (state_reg == S_IDLE && move) cur_dir <= pend_dir;
    end
  end

  always_comb begin
    rd_x      = '0;
    rd_y      = '0;
    rd_active = 1'b0;
    if (rd_index < len_reg) begin
      rd_active = 1'b1;
      rd_x      = seg_x[rd_index[IW-1:0]];
      rd_y      = seg_y[rd_index[IW-1:0]];
    end
  end

  assign head_x = seg_x[0];
  assign head_y = seg_y[0];
  assign length = len_reg;

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body: reset, stepping, turning, growth, wall/self collision, busy and reset-mid-scan.
module tb_snake_body;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       move = 1'b0;
  logic       dir_valid = 1'b0;
  logic [1:0] dir = 2'd0;
  logic [5:0] fruit_x = 6'd0;
  logic [4:0] fruit_y = 5'd0;
  logic [5:0] rd_index = 6'd0;
  logic [5:0] rd_x;
  logic [4:0] rd_y;
  logic       rd_active;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic [5:0] length;
  logic       busy;
  logic       ate_fruit;
  logic       endgame;

  int total = 0;
  int bad   = 0;

  snake_body dut (
    .clock     (clock),
    .resetn    (resetn),
    .move      (move),
    .dir_valid (dir_valid),
    .dir       (dir),
    .fruit_x   (fruit_x),
    .fruit_y   (fruit_y),
    .rd_index  (rd_index),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .rd_active (rd_active),
    .head_x    (head_x),
    .head_y    (head_y),
    .length    (length),
    .busy      (busy),
    .ate_fruit (ate_fruit),
    .endgame   (endgame)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn  = 1'b0;
    fruit_x = 6'd0;
    fruit_y = 5'd0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic press(input logic [1:0] d);
    dir_valid = 1'b1;
    dir       = d;
    tick();
    dir_valid = 1'b0;
  endtask

  // cyc counts samples from the S_CALC cycle until idle; *_at is the sample index of the pulse.
  task automatic do_move(output int cyc, output int ate_n, output int ate_at,
                         output int end_n, output int end_at);
    move = 1'b1;
    tick();
    move   = 1'b0;
    cyc    = 0;
    ate_n  = 0;
    end_n  = 0;
    ate_at = -1;
    end_at = -1;
    while (busy === 1'b1 && cyc < 100) begin
      if (ate_fruit === 1'b1) begin ate_n++; ate_at = cyc; end
      if (endgame === 1'b1)   begin end_n++; end_at = cyc; end
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({busy, ate_fruit, endgame} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %b want 000", {busy, ate_fruit, endgame});
    end
    total++;
    if ({head_x, head_y, length} !== {6'd20, 5'd15, 6'd3}) begin
      bad++; $display("FAIL reset_head: got (%0d,%0d) len %0d want (20,15) len 3", head_x, head_y, length);
    end
    rd_index = 6'd2;
    #1;
    total++;
    if ({rd_active, rd_x, rd_y} !== {1'b1, 6'd18, 5'd15}) begin
      bad++; $display("FAIL reset_seg2: got act %b (%0d,%0d) want 1 (18,15)", rd_active, rd_x, rd_y);
    end
    rd_index = 6'd3;
    #1;
    total++;
    if ({rd_active, rd_x, rd_y} !== {1'b0, 6'd0, 5'd0}) begin
      bad++; $display("FAIL reset_seg3_inactive: got act %b (%0d,%0d) want 0 (0,0)", rd_active, rd_x, rd_y);
    end
    rd_index = 6'd63;
    #1;
    total++;
    if ({rd_active, rd_x, rd_y} !== {1'b0, 6'd0, 5'd0}) begin
      bad++; $display("FAIL reset_seg63_inactive: got act %b (%0d,%0d) want 0 (0,0)", rd_active, rd_x, rd_y);
    end
  endtask

  task automatic test_first_move();
    int cyc, an, aa, en, ea;
    do_reset();
    do_move(cyc, an, aa, en, ea);
    total++;
    if (cyc !== 4) begin bad++; $display("FAIL first_move_latency: got %0d want 4", cyc); end
    total++;
    if ({head_x, head_y, length} !== {6'd21, 5'd15, 6'd3}) begin
      bad++; $display("FAIL first_move_head: got (%0d,%0d) len %0d want (21,15) len 3", head_x, head_y, length);
    end
    rd_index = 6'd2;
    #1;
    total++;
    if ({rd_active, rd_x, rd_y} !== {1'b1, 6'd19, 5'd15}) begin
      bad++; $display("FAIL first_move_seg2: got act %b (%0d,%0d) want 1 (19,15)", rd_active, rd_x, rd_y);
    end
    total++;
    if ({an, en} !== {32'd0, 32'd0}) begin
      bad++; $display("FAIL first_move_pulses: got ate %0d end %0d want 0 0", an, en);
    end
  endtask

  task automatic test_direction();
    int cyc, an, aa, en, ea;
    do_reset();
    press(2'd0);
    press(2'd2);
    do_move(cyc, an, aa, en, ea);
    total++;
    if ({head_x, head_y, en[0]} !== {6'd20, 5'd14, 1'b0}) begin
      bad++; $display("FAIL dir_up_left: got (%0d,%0d) end %0d want (20,14) end 0", head_x, head_y, en);
    end
    press(2'd3);
    do_move(cyc, an, aa, en, ea);
    total++;
    if ({head_x, head_y} !== {6'd20, 5'd13}) begin
      bad++; $display("FAIL dir_reverse_down: got (%0d,%0d) want (20,13)", head_x, head_y);
    end
    press(2'd2);
    do_move(cyc, an, aa, en, ea);
    total++;
    if ({head_x, head_y} !== {6'd19, 5'd13}) begin
      bad++; $display("FAIL dir_left: got (%0d,%0d) want (19,13)", head_x, head_y);
    end
  endtask

  task automatic test_fruit();
    int cyc, an, aa, en, ea;
    do_reset();
    fruit_x = 6'd21;
    fruit_y = 5'd15;
    do_move(cyc, an, aa, en, ea);
    fruit_x = 6'd0;
    fruit_y = 5'd0;
    total++;
    if ({an, aa} !== {32'd1, 32'd4}) begin
      bad++; $display("FAIL fruit_pulse: got count %0d at %0d want count 1 at 4", an, aa);
    end
    total++;
    if (cyc !== 5) begin bad++; $display("FAIL fruit_latency: got %0d want 5", cyc); end
    total++;
    if ({head_x, head_y, length} !== {6'd21, 5'd15, 6'd4}) begin
      bad++; $display("FAIL fruit_len: got (%0d,%0d) len %0d want (21,15) len 4", head_x, head_y, length);
    end
    rd_index = 6'd3;
    #1;
    total++;
    if ({rd_active, rd_x, rd_y} !== {1'b1, 6'd18, 5'd15}) begin
      bad++; $display("FAIL fruit_tail: got act %b (%0d,%0d) want 1 (18,15)", rd_active, rd_x, rd_y);
    end
    total++;
    if (ate_fruit !== 1'b0) begin bad++; $display("FAIL fruit_pulse_clear: got %b want 0", ate_fruit); end
  endtask

  task automatic test_wall();
    int cyc, an, aa, en, ea;
    do_reset();
    for (int i = 0; i < 19; i++) do_move(cyc, an, aa, en, ea);
    total++;
    if ({head_x, head_y} !== {6'd39, 5'd15}) begin
      bad++; $display("FAIL wall_approach: got (%0d,%0d) want (39,15)", head_x, head_y);
    end
    do_move(cyc, an, aa, en, ea);
`ifdef SNAKE_WRAP_EN
    total++;
    if ({head_x, head_y, length, en[0]} !== {6'd0, 5'd15, 6'd3, 1'b0}) begin
      bad++; $display("FAIL wall_wrap: got (%0d,%0d) len %0d end %0d want (0,15) len 3 end 0",
                      head_x, head_y, length, en);
    end
`else
    total++;
    if ({en, ea} !== {32'd1, 32'd1}) begin
      bad++; $display("FAIL wall_endgame: got count %0d at %0d want count 1 at 1", en, ea);
    end
    total++;
    if ({head_x, head_y, length, busy} !== {6'd20, 5'd15, 6'd3, 1'b0}) begin
      bad++; $display("FAIL wall_respawn: got (%0d,%0d) len %0d busy %b want (20,15) len 3 busy 0",
                      head_x, head_y, length, busy);
    end
`endif
  endtask

  task automatic test_self_collision();
    int cyc, an, aa, en, ea;
    do_reset();
    fruit_x = 6'd21; fruit_y = 5'd15;
    do_move(cyc, an, aa, en, ea);
    fruit_x = 6'd22; fruit_y = 5'd15;
    do_move(cyc, an, aa, en, ea);
    fruit_x = 6'd0;  fruit_y = 5'd0;
    total++;
    if ({head_x, head_y, length} !== {6'd22, 5'd15, 6'd5}) begin
      bad++; $display("FAIL self_grow: got (%0d,%0d) len %0d want (22,15) len 5", head_x, head_y, length);
    end
    press(2'd3);
    do_move(cyc, an, aa, en, ea);
    press(2'd2);
    do_move(cyc, an, aa, en, ea);
    total++;
    if ({head_x, head_y, en[0]} !== {6'd21, 5'd16, 1'b0}) begin
      bad++; $display("FAIL self_turns: got (%0d,%0d) end %0d want (21,16) end 0", head_x, head_y, en);
    end
    press(2'd0);
    do_move(cyc, an, aa, en, ea);
    total++;
    if ({en, ea} !== {32'd1, 32'd5}) begin
      bad++; $display("FAIL self_endgame: got count %0d at %0d want count 1 at 5", en, ea);
    end
    total++;
    if ({head_x, head_y, length} !== {6'd20, 5'd15, 6'd3}) begin
      bad++; $display("FAIL self_respawn: got (%0d,%0d) len %0d want (20,15) len 3", head_x, head_y, length);
    end
  endtask

  task automatic test_busy_ignore();
    do_reset();
    move = 1'b1;
    tick();
    move = 1'b0;
    tick();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_high: got %b want 1", busy); end
    move = 1'b1;
    tick();
    move = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy !== 1'b1) break;
      tick();
    end
    tick();
    tick();
    total++;
    if ({head_x, head_y, busy} !== {6'd21, 5'd15, 1'b0}) begin
      bad++; $display("FAIL busy_move_dropped: got (%0d,%0d) busy %b want (21,15) busy 0", head_x, head_y, busy);
    end
  endtask

  task automatic test_reset_mid_scan();
    int cyc, an, aa, en, ea;
    do_reset();
    press(2'd0);
    move = 1'b1;
    tick();
    move = 1'b0;
    tick();
    resetn = 1'b0;
    tick();
    total++;
    if ({busy, head_x, head_y, length} !== {1'b0, 6'd20, 5'd15, 6'd3}) begin
      bad++; $display("FAIL reset_mid_scan: got busy %b (%0d,%0d) len %0d want busy 0 (20,15) len 3",
                      busy, head_x, head_y, length);
    end
    resetn = 1'b1;
    do_move(cyc, an, aa, en, ea);
    total++;
    if ({head_x, head_y} !== {6'd21, 5'd15}) begin
      bad++; $display("FAIL reset_dir_restored: got (%0d,%0d) want (21,15)", head_x, head_y);
    end
  endtask

  initial begin
    test_reset();
    test_first_move();
    test_direction();
    test_fruit();
    test_wall();
    test_self_collision();
    test_busy_ignore();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
